// File: rtl/qed_i_cache.sv
// qed_i_cache: SQED instruction replay buffer.
// Original phase captures valid non-NOP fetches in order while passing fetch
// through; duplicate phase replays the captured stream in the same order.
module qed_i_cache #(
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = 4,
  parameter logic [31:0] NOP    = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec_dup,
  input  logic              IF_stall,
  input  logic              ifu_vld,
  input  logic [31:0]       ifu_qed_instruction,
  output logic [31:0]       qic_qimux_instruction,
  output logic              qic_vld,
  output logic              qic_full,
  output logic              qic_empty,
  output logic [ADDR_W:0]   qic_count,
  output logic              qic_overflow,
  output logic              qic_drained
);

  // Storage is deliberately not reset; the pointers alone define occupancy.
  logic [31:0]     mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic            push_req, push, pop;

  // Occupancy flags, derived purely from the pointers (MSB is the wrap flag).
  always_comb begin
    qic_count = wr_ptr - rd_ptr;
    qic_empty = (wr_ptr == rd_ptr);
    qic_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  end

  // Push/pop qualification; exec_dup makes the two mutually exclusive.
  always_comb begin
    push_req = !exec_dup && ifu_vld && !IF_stall && (ifu_qed_instruction != NOP);
    push     = push_req && !qic_full;
    pop      = exec_dup && !IF_stall && !qic_empty;
  end

  // Output mux: passthrough in original phase, head of buffer in duplicate.
  always_comb begin
    if (!exec_dup) begin
      qic_qimux_instruction = ifu_qed_instruction;
      qic_vld               = ifu_vld;
    end else begin
      qic_qimux_instruction = qic_empty ? NOP : mem[rd_ptr[ADDR_W-1:0]];
      qic_vld               = !qic_empty;
    end
  end

  // Capture write into storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= ifu_qed_instruction;
  end

  // Pointer, sticky overflow and drained-pulse state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      qic_overflow <= 1'b0;
      qic_drained  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && qic_full) qic_overflow <= 1'b1;
      qic_drained <= pop && (qic_count == (ADDR_W+1)'(1));
    end
  end

endmodule
